bch_key_arbiter: RTL

- Shares one serial key-equation solver (bch_sigma_bma_serial) between CHANNELS independent bch_syndrome units.
- Each syndrome unit's result is captured into a per-channel holding register. A scheduler then dispatches one pending syndrome set at a time to the solver and tags the result with the owning channel.
- Sits between the syndrome stage and the solver/error-locator stage in a multi-lane decoder.

---
 rtl/bch_key_arbiter_if.sv | 31 +++
 rtl/bch_key_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bch_key_arbiter_if.sv
// Handshake bundle between the syndrome units, the shared key-equation solver
// and the downstream consumer. The arbiter connects through the master modport.
interface bch_key_arbiter_if #(
    parameter int CHANNELS = 4,
    parameter int SYN_SZ   = 48
);
    localparam int CHAN_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]        syn_done;
    logic [CHANNELS*SYN_SZ-1:0] syn_in;
    logic                       key_ready;
    logic                       key_start;
    logic [SYN_SZ-1:0]          key_syndromes;
    logic                       key_done;
    logic                       key_ack;
    logic                       out_done;
    logic [CHAN_BITS-1:0]       out_chan;
    logic                       out_ack;
    logic [CHANNELS-1:0]        pending;
    logic [CHANNELS-1:0]        overrun;

    modport master (
        input  syn_done, syn_in, key_ready, key_done, out_ack,
        output key_start, key_syndromes, key_ack, out_done, out_chan, pending, overrun
    );

    modport slave (
        output syn_done, syn_in, key_ready, key_done, out_ack,
        input  key_start, key_syndromes, key_ack, out_done, out_chan, pending, overrun
    );
endinterface

// File: rtl/bch_key_arbiter.sv
// Shares one serial key-equation solver between CHANNELS syndrome units.
// Define BCH_KEY_ARB_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module bch_key_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SYN_SZ   = 48
) (
    input  logic              clk,
    input  logic              reset,
    bch_key_arbiter_if.master bus
);
    localparam int CHAN_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 key_start_q, key_start_d;
    logic [SYN_SZ-1:0]    key_syn_q, key_syn_d;
    logic [CHAN_BITS-1:0] owner_q, owner_d;
    logic [CHAN_BITS-1:0] out_chan_q, out_chan_d;
    logic                 out_done_q, out_done_d;
    logic [CHANNELS-1:0]  pending_q, pending_d;
    logic [CHANNELS-1:0]  overrun_q, overrun_d;
    logic [SYN_SZ-1:0]    hold_q [CHANNELS];
    logic [SYN_SZ-1:0]    hold_d [CHANNELS];
    logic                 grant_s;
    logic [CHANNELS-1:0]  grant_oh_s;
    int                   gnt_idx_s;
`ifdef BCH_KEY_ARB_FIXED_PRIORITY_EN
`else
    logic [CHAN_BITS-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Pick the winning pending channel; scanning downward lets the best candidate land last.
    always_comb begin
        gnt_idx_s  = 0;
        grant_s    = 1'b0;
        grant_oh_s = {CHANNELS{1'b0}};
        for (int k = CHANNELS - 1; k >= 0; k--) begin
`ifdef BCH_KEY_ARB_FIXED_PRIORITY_EN
            if (pending_q[k]) begin
                gnt_idx_s = k;
                grant_s   = 1'b1;
            end else begin
                grant_s   = grant_s;
            end
`else
            if (pending_q[(int'(rr_ptr_q) + k) % CHANNELS]) begin
                gnt_idx_s = (int'(rr_ptr_q) + k) % CHANNELS;
                grant_s   = 1'b1;
            end else begin
                grant_s   = grant_s;
            end
`endif
        end
        if (state_q == IDLE && bus.key_ready) begin
            grant_s = grant_s;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            grant_oh_s[gnt_idx_s] = 1'b1;
        end else begin
            grant_oh_s = {CHANNELS{1'b0}};
        end
    end

    // Next-state, dispatch and capture logic.
    always_comb begin
        state_d     = state_q;
        key_start_d = 1'b0;
        key_syn_d   = key_syn_q;
        owner_d     = owner_q;
        out_chan_d  = out_chan_q;
        out_done_d  = out_done_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        hold_d      = hold_q;
`ifdef BCH_KEY_ARB_FIXED_PRIORITY_EN
`else
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    key_start_d = 1'b1;
                    key_syn_d   = hold_q[gnt_idx_s];
                    owner_d     = CHAN_BITS'(gnt_idx_s);
                    pending_d   = pending_q & ~grant_oh_s;
                    state_d     = BUSY;
`ifdef BCH_KEY_ARB_FIXED_PRIORITY_EN
`else
                    rr_ptr_d    = CHAN_BITS'((gnt_idx_s + 1) % CHANNELS);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (bus.key_done) begin
                    out_done_d = 1'b1;
                    out_chan_d = owner_q;
                    state_d    = WAIT_ACK;
                end else begin
                    state_d = BUSY;
                end
            end
            WAIT_ACK: begin
                if (bus.out_ack) begin
                    out_done_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A slot being dispatched this cycle is free to take new data.
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.syn_done[i]) begin
                if (!pending_q[i] || grant_oh_s[i]) begin
                    hold_d[i]    = bus.syn_in[i*SYN_SZ +: SYN_SZ];
                    pending_d[i] = 1'b1;
                end else begin
                    overrun_d[i] = 1'b1;
                end
            end else begin
                hold_d[i] = hold_d[i];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            key_start_q <= 1'b0;
            key_syn_q   <= {SYN_SZ{1'b0}};
            owner_q     <= {CHAN_BITS{1'b0}};
            out_chan_q  <= {CHAN_BITS{1'b0}};
            out_done_q  <= 1'b0;
            pending_q   <= {CHANNELS{1'b0}};
            overrun_q   <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= {SYN_SZ{1'b0}};
            end
`ifdef BCH_KEY_ARB_FIXED_PRIORITY_EN
`else
            rr_ptr_q    <= {CHAN_BITS{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            key_start_q <= key_start_d;
            key_syn_q   <= key_syn_d;
            owner_q     <= owner_d;
            out_chan_q  <= out_chan_d;
            out_done_q  <= out_done_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            hold_q      <= hold_d;
`ifdef BCH_KEY_ARB_FIXED_PRIORITY_EN
`else
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // The solver stays held until the downstream consumer takes the result.
    assign bus.key_ack       = (state_q == WAIT_ACK) && bus.out_ack;
    assign bus.key_start     = key_start_q;
    assign bus.key_syndromes = key_syn_q;
    assign bus.out_done      = out_done_q;
    assign bus.out_chan      = out_chan_q;
    assign bus.pending       = pending_q;
    assign bus.overrun       = overrun_q;
endmodule
